// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes ALU register/immediate requests into RV32 words; large
//            ADDI immediates with rs1=x0 expand into a LUI+ADDI pair.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_funct,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [4:0]   rd,
    input  logic [N-1:0] immed,
    input  logic         use_immed,
    output logic [N-1:0] instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         err
);

    localparam logic [6:0] c_OP_REG = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT1 = 2'd1,
        S_EMIT2 = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_instr;
    logic [N-1:0]   w_instr_nxt;
    logic [N-1:0]   r_word2;
    logic [N-1:0]   w_word2_nxt;
    logic           r_out_last;
    logic           w_last_nxt;
    logic           r_err;
    logic           w_err_nxt;

    logic [2:0]     w_funct3;
    logic           w_is_shift;
    logic           w_imm_small;
    logic [N-13:0]  w_hi;
    logic [N-1:0]   w_r_word;
    logic [N-1:0]   w_shift_word;
    logic [N-1:0]   w_itype_word;
    logic [N-1:0]   w_lui_word;
    logic [N-1:0]   w_addi_word;
    logic           w_legal;
    logic [N-1:0]   w_first;
    logic           w_first_last;
    logic           w_xfer;
    logic           w_accept;

    assign w_funct3    = alu_funct[2:0];
    assign w_is_shift  = (w_funct3 == 3'b001) | (w_funct3 == 3'b101);
    assign w_imm_small = (immed[N-1:11] == '0) | (immed[N-1:11] == '1);
    // Adding 0x800 before taking [N-1:12] only carries in when bit 11 is set.
    assign w_hi        = immed[N-1:12] + (N-12)'(immed[11]);

    assign w_r_word     = N'({1'b0, alu_funct[3], 5'b0, rs2, rs1, w_funct3, rd, c_OP_REG});
    assign w_shift_word = N'({1'b0, alu_funct[3], 5'b0, immed[4:0], rs1, w_funct3, rd, c_OP_IMM});
    assign w_itype_word = N'({immed[11:0], rs1, w_funct3, rd, c_OP_IMM});
    assign w_lui_word   = {w_hi, rd, c_OP_LUI};
    assign w_addi_word  = N'({immed[11:0], rd, 3'b000, rd, c_OP_IMM});

    always_comb begin
        w_legal      = 1'b0;
        w_first      = w_r_word;
        w_first_last = 1'b1;
        if (!use_immed) begin
            w_legal = 1'b1;
        end else if (w_is_shift) begin
            w_legal = (immed[N-1:5] == '0);
            w_first = w_shift_word;
        end else if (alu_funct[3]) begin
            w_legal = 1'b0;
        end else if (w_imm_small) begin
            w_legal = 1'b1;
            w_first = w_itype_word;
        end else if ((w_funct3 == 3'b000) && (rs1 == 5'd0)) begin
            w_legal      = 1'b1;
            w_first      = w_lui_word;
            w_first_last = (immed[11:0] == 12'd0);
        end
    end

    assign out_valid = (r_state != S_IDLE);
    assign instr     = r_instr;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign w_xfer    = out_valid & out_ready;
    assign in_ready  = (r_state == S_IDLE) | (w_xfer & r_out_last);
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_last_nxt  = r_out_last;
        w_word2_nxt = r_word2;
        w_err_nxt   = 1'b0;
        if (w_xfer) begin
            if ((r_state == S_EMIT1) && !r_out_last) begin
                w_state_nxt = S_EMIT2;
                w_instr_nxt = r_word2;
                w_last_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_last_nxt  = 1'b0;
            end
        end
        // An accept only happens from IDLE or on the final word's transfer.
        if (w_accept) begin
            if (w_legal) begin
                w_state_nxt = S_EMIT1;
                w_instr_nxt = w_first;
                w_last_nxt  = w_first_last;
                w_word2_nxt = w_addi_word;
            end else begin
                w_state_nxt = S_IDLE;
                w_last_nxt  = 1'b0;
                w_err_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_word2    <= '0;
            r_out_last <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_instr    <= w_instr_nxt;
            r_word2    <= w_word2_nxt;
            r_out_last <= w_last_nxt;
            r_err      <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed and randomized bench for instr_encoder against a
//            word-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] immed;
    logic        use_immed;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err;

    instr_encoder #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_funct (alu_funct),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .immed     (immed),
        .use_immed (use_immed),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } exp_t;

    exp_t        r_q[$];
    logic        r_err_exp;
    int          n_checks;
    int          n_fail;
    logic [31:0] s_instr;
    logic        s_valid;
    logic        s_last;
    logic        s_err;
    logic        s_in_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding built arithmetically from field values.
    function automatic void ref_encode(input logic [3:0] f, input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] d, input logic [31:0] imm, input logic ui,
                                       output bit legal, output int n,
                                       output logic [31:0] w0, output logic [31:0] w1);
        int          f3 = int'(f[2:0]);
        int          si = $signed(imm);
        logic [31:0] lo = imm & 32'hFFF;
        logic [31:0] hi;
        legal = 1'b1;
        n     = 1;
        w0    = 32'd0;
        w1    = 32'd0;
        if (!ui) begin
            w0 = (32'(f[3]) << 30) | (32'(b) << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h33;
        end else if (f3 == 1 || f3 == 5) begin
            legal = (imm < 32);
            w0 = (32'(f[3]) << 30) | ((imm & 32'h1F) << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
        end else if (f[3]) begin
            legal = 1'b0;
        end else if (si >= -2048 && si <= 2047) begin
            w0 = (lo << 20) | (32'(a) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
        end else if (f3 == 0 && a == 5'd0) begin
            hi = (imm + 32'h800) >> 12;
            w0 = (hi << 12) | (32'(d) << 7) | 32'h37;
            if (lo != 0) begin
                n  = 2;
                w1 = (lo << 20) | (32'(d) << 15) | (32'(d) << 7) | 32'h13;
            end
        end else begin
            legal = 1'b0;
        end
    endfunction

    // One clock cycle: sample/check at negedge, then advance the model past posedge.
    task automatic cycle();
        bit          xfer;
        bit          acc;
        bit          legal;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        exp_t        e;
        @(negedge clk);
        s_instr    = instr;
        s_valid    = out_valid;
        s_last     = out_last;
        s_err      = err;
        s_in_ready = in_ready;
        check_eq("out_valid", 32'(out_valid), 32'(r_q.size() != 0));
        check_eq("err", 32'(err), 32'(r_err_exp));
        check_eq("in_ready", 32'(in_ready), 32'((r_q.size() == 0) || (out_ready && r_q.size() == 1)));
        if (r_q.size() != 0) begin
            check_eq("instr", instr, r_q[0].w);
            check_eq("out_last", 32'(out_last), 32'(r_q[0].last));
        end
        xfer = !rst && (r_q.size() != 0) && out_ready;
        acc  = !rst && in_valid && ((r_q.size() == 0) || (out_ready && r_q.size() == 1));
        ref_encode(alu_funct, rs1, rs2, rd, immed, use_immed, legal, n, w0, w1);
        @(posedge clk);
        #1;
        r_err_exp = 1'b0;
        if (rst) begin
            r_q.delete();
        end else begin
            if (xfer) void'(r_q.pop_front());
            if (acc) begin
                if (legal) begin
                    e.w = w0; e.last = (n == 1); r_q.push_back(e);
                    if (n == 2) begin e.w = w1; e.last = 1'b1; r_q.push_back(e); end
                end else begin
                    r_err_exp = 1'b1;
                end
            end
        end
    endtask

    task automatic set_req(input logic v, input logic [3:0] f, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [31:0] imm, input logic ui);
        in_valid = v; alu_funct = f; rs1 = a; rs2 = b; rd = d; immed = imm; use_immed = ui;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic rand_req();
        int         cat;
        logic [11:0] r12;
        cat       = $urandom_range(0, 5);
        r12       = 12'($urandom);
        in_valid  = 1'b1;
        use_immed = 1'b1;
        alu_funct = 4'($urandom);
        rs1       = 5'($urandom);
        rs2       = 5'($urandom);
        rd        = 5'($urandom);
        immed     = $urandom;
        case (cat)
            0: use_immed = 1'b0;
            1: begin
                alu_funct[2:0] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                if ($urandom_range(0, 3) != 0) immed = 32'($urandom_range(0, 31));
            end
            2: begin
                alu_funct[3] = ($urandom_range(0, 7) == 0);
                if (alu_funct[2:0] == 3'd1 || alu_funct[2:0] == 3'd5) alu_funct[2:0] = 3'd0;
                immed = {{20{r12[11]}}, r12};
            end
            3: begin
                alu_funct = 4'd0;
                rs1       = 5'd0;
                if ($urandom_range(0, 2) == 0) immed[11:0] = 12'd0;
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        r_err_exp = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        set_req(0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        cycle();
        check_eq("rst_instr", s_instr, 32'd0);
        check_eq("rst_last", 32'(s_last), 32'd0);
        rst = 1'b0;
        cycle();
        check_eq("ready_after_rst", 32'(s_in_ready), 32'd1);

        // R-type pair, back to back
        set_req(1, 4'b0000, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 1'b0); cycle();
        set_req(1, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0); cycle();
        check_eq("rtype_add", s_instr, 32'h002081B3);
        idle(); cycle();
        check_eq("rtype_sub", s_instr, 32'h402081B3);
        check_eq("rtype_sub_last", 32'(s_last), 32'd1);

        set_req(1, 4'b0000, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b1); cycle();
        idle(); cycle();
        check_eq("addi_neg", s_instr, 32'hFFF00293);
        check_eq("addi_last", 32'(s_last), 32'd1);

        // Expansion under back-pressure, then a back-to-back request
        set_req(1, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h12345FFF, 1'b1); cycle();
        idle(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("bp_lui_hold", s_instr, 32'h123462B7);
            check_eq("bp_in_ready", 32'(s_in_ready), 32'd0);
        end
        out_ready = 1'b1; cycle();
        check_eq("exp_lui_last", 32'(s_last), 32'd0);
        set_req(1, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0); cycle();
        check_eq("exp_addi", s_instr, 32'hFFF28293);
        check_eq("exp_addi_last", 32'(s_last), 32'd1);
        idle(); cycle();
        check_eq("b2b_word", s_instr, 32'h002081B3);

        set_req(1, 4'b0000, 5'd0, 5'd0, 5'd1, 32'h00010000, 1'b1); cycle();
        idle(); cycle();
        check_eq("lui_only", s_instr, 32'h000100B7);
        check_eq("lui_only_last", 32'(s_last), 32'd1);

        set_req(1, 4'b0000, 5'd0, 5'd0, 5'd2, 32'h7FFFF800, 1'b1); cycle();
        idle(); cycle();
        check_eq("wrap_lui", s_instr, 32'h80000137);
        cycle();
        check_eq("wrap_addi", s_instr, 32'h80010113);

        set_req(1, 4'b0001, 5'd3, 5'd0, 5'd4, 32'd32, 1'b1); cycle();
        idle(); cycle();
        check_eq("slli_err", 32'(s_err), 32'd1);
        check_eq("slli_valid", 32'(s_valid), 32'd0);

        set_req(1, 4'b0000, 5'd2, 5'd0, 5'd4, 32'h00001000, 1'b1); cycle();
        idle(); cycle();
        check_eq("rs1_err", 32'(s_err), 32'd1);
        check_eq("rs1_valid", 32'(s_valid), 32'd0);

        // Reset while the ADDI half is pending
        set_req(1, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h12345FFF, 1'b1); cycle();
        idle(); cycle();
        rst = 1'b1; cycle();
        check_eq("emit2_word", s_instr, 32'hFFF28293);
        rst = 1'b0; cycle();
        check_eq("rst_emit2_valid", 32'(s_valid), 32'd0);
        check_eq("rst_emit2_ready", 32'(s_in_ready), 32'd1);

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) rand_req();
            else idle();
            cycle();
        end
        rst = 1'b0; out_ready = 1'b1; idle();
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
